nrzi_decoder: RTL and testbench

//  Receive-side counterpart of the team's NRZI encoder. Samples the NRZI line `z` one bit per

---
 rtl/nrzi_pkg.sv | 28 ++
 rtl/nrzi_decoder_if.sv | 30 +++
 rtl/nrzi_bit_decode.sv | 71 +++++++
 rtl/nrzi_decoder.sv | 95 +++++++++
 tb/tb_nrzi_decoder.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nrzi_pkg.sv
// ============================================================================
// nrzi_pkg : shared types and width helpers for the NRZI receive path
// Rev 1.0
// ============================================================================
`default_nettype none

package nrzi_pkg;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_DATA  = 2'd1,
        ST_STUFF = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_STUFF_LEN = 6;

    function automatic int bit_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int ones_cnt_w(input int stuff_len);
        return (stuff_len > 0) ? $clog2(stuff_len + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nrzi_decoder_if.sv
// ============================================================================
// nrzi_decoder_if : line input and decoded-word output bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface nrzi_decoder_if #(
    parameter int WIDTH = 8
);
    logic             z;
    logic             z_valid;
    logic             align;
    logic [WIDTH-1:0] data;
    logic             data_valid;
    logic             data_ready;
    logic             overflow;
    logic             stuff_err;

    modport master (
        output z, z_valid, align, data_ready,
        input  data, data_valid, overflow, stuff_err
    );

    modport slave (
        input  z, z_valid, align, data_ready,
        output data, data_valid, overflow, stuff_err
    );
endinterface

`default_nettype wire

// File: rtl/nrzi_bit_decode.sv
// ============================================================================
// nrzi_bit_decode : NRZI level-to-bit decoder with stuff-bit removal
// Rev 1.0
// ============================================================================
`default_nettype none

module nrzi_bit_decode
    import nrzi_pkg::*;
#(
    parameter int STUFF_EN  = 1,
    parameter int STUFF_LEN = DEF_STUFF_LEN
) (
    input  logic clock,
    input  logic reset,
    input  logic z,
    input  logic z_valid,
    input  logic align,
    output logic dec_bit,
    output logic bit_valid,
    output logic abort
);
    localparam int OCW = ones_cnt_w(STUFF_LEN);

    state_t           state;
    logic             prev_z;
    logic [OCW-1:0]   ones_cnt;
    logic [OCW-1:0]   ones_next;
    logic             sample;

    // Bit outputs are combinational so the top can pack the bit on the sampling edge.
    always_comb begin
        sample    = z_valid && !align;
        dec_bit   = ~(z ^ prev_z);
        bit_valid = sample && (state == ST_DATA);
        abort     = sample && (state == ST_STUFF) && dec_bit;
        ones_next = '0;
        if (dec_bit) begin
            ones_next = (ones_cnt == OCW'(STUFF_LEN)) ? ones_cnt : ones_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_HUNT;
            prev_z   <= 1'b0;
            ones_cnt <= '0;
        end else if (align) begin
            state    <= ST_HUNT;
            ones_cnt <= '0;
        end else if (z_valid) begin
            prev_z <= z;
            case (state)
                ST_HUNT: state <= ST_DATA;
                ST_DATA: begin
                    ones_cnt <= ones_next;
                    if ((STUFF_EN != 0) && (ones_next == OCW'(STUFF_LEN))) begin
                        state <= ST_STUFF;
                    end
                end
                ST_STUFF: begin
                    ones_cnt <= '0;
                    state    <= ST_DATA;
                end
                default: state <= ST_HUNT;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/nrzi_decoder.sv
// ============================================================================
// nrzi_decoder : NRZI receiver, LSB-first word packer and valid/ready output
// Rev 1.0
// ============================================================================
`default_nettype none

module nrzi_decoder
    import nrzi_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int STUFF_EN  = 1,
    parameter int STUFF_LEN = DEF_STUFF_LEN
) (
    input  logic           clock,
    input  logic           reset,
    nrzi_decoder_if.slave  bus
);
    localparam int BCW = bit_cnt_w(WIDTH);

    logic             dec_bit;
    logic             bit_valid;
    logic             abort;

    logic [WIDTH-1:0] shift_reg;
    logic [BCW-1:0]   bit_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_data_valid;
    logic             r_overflow;
    logic             r_stuff_err;

    logic [WIDTH-1:0] shift_next;
    logic             word_done;
    logic             xfer;

    nrzi_bit_decode #(
        .STUFF_EN  (STUFF_EN),
        .STUFF_LEN (STUFF_LEN)
    ) u_bit_decode (
        .clock     (clock),
        .reset     (reset),
        .z         (bus.z),
        .z_valid   (bus.z_valid),
        .align     (bus.align),
        .dec_bit   (dec_bit),
        .bit_valid (bit_valid),
        .abort     (abort)
    );

    always_comb begin
        shift_next = {dec_bit, shift_reg[WIDTH-1:1]};
        word_done  = bit_valid && (bit_cnt == BCW'(WIDTH - 1));
        xfer       = r_data_valid && bus.data_ready;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_stuff_err  <= 1'b0;
        end else begin
            r_stuff_err <= abort;

            if (bus.align || abort) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (bit_valid) begin
                shift_reg <= shift_next;
                bit_cnt   <= word_done ? '0 : bit_cnt + 1'b1;
            end

            // A finished word may reuse the slot being drained on this same edge.
            if (word_done) begin
                if (!r_data_valid || xfer) begin
                    r_data       <= shift_next;
                    r_data_valid <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (xfer) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign bus.data       = r_data;
    assign bus.data_valid = r_data_valid;
    assign bus.overflow   = r_overflow;
    assign bus.stuff_err  = r_stuff_err;

endmodule

`default_nettype wire

// File: tb/tb_nrzi_decoder.sv
// ============================================================================
// tb_nrzi_decoder : scoreboard bench for nrzi_decoder (WIDTH=8, stuffing after 6 ones)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_nrzi_decoder;

    logic clock;
    logic reset;

    nrzi_decoder_if #(.WIDTH(8)) bus();

    nrzi_decoder #(
        .WIDTH     (8),
        .STUFF_EN  (1),
        .STUFF_LEN (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         valid_cycles = 0;
    int         stuff_pulses = 0;

    logic line = 1'b0;
    int   ones = 0;

    // Observe accepted words and pulse counts midway between active edges.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.data_valid && bus.data_ready) obs_q.push_back(bus.data);
            if (bus.data_valid) valid_cycles++;
            if (bus.stuff_err)  stuff_pulses++;
        end
    end

    task automatic drive(input logic lvl);
        bus.z       = lvl;
        bus.z_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.z_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_ref(input logic lvl);
        line = lvl;
        ones = 0;
        drive(lvl);
    endtask

    task automatic send_data_bit(input logic b);
        if (!b) line = ~line;
        drive(line);
    endtask

    // Independent NRZI + stuffing encoder; ones run continues across words.
    task automatic send_word(input logic [7:0] w, input bit push);
        logic [7:0] wv;
        wv = w;
        for (int i = 0; i < 8; i++) begin
            send_data_bit(wv[i]);
            if (wv[i]) ones++; else ones = 0;
            if (ones == 6) begin
                send_data_bit(1'b0);
                ones = 0;
            end
        end
        if (push) exp_q.push_back(w);
    endtask

    task automatic do_reset();
        bus.z_valid = 1'b0;
        bus.align   = 1'b0;
        reset       = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        obs_q.delete();
        valid_cycles = 0;
        stuff_pulses = 0;
        line = 1'b0;
        ones = 0;
    endtask

    task automatic test_reset();
        n_vec++;
        if (bus.data !== 8'h00) begin
            n_err++; $display("FAIL reset_data: got %h want 00", bus.data);
        end
        n_vec++;
        if (bus.data_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b want 0", bus.data_valid);
        end
        n_vec++;
        if (bus.overflow !== 1'b0) begin
            n_err++; $display("FAIL reset_overflow: got %b want 0", bus.overflow);
        end
        n_vec++;
        if (bus.stuff_err !== 1'b0) begin
            n_err++; $display("FAIL reset_stuff_err: got %b want 0", bus.stuff_err);
        end
    endtask

    task automatic run_a5(input string tag);
        logic [8:0] lv;
        logic [7:0] e;
        bus.data_ready = 1'b1;
        lv = 9'b0_0110_1100;        // lv[8]=ref, then 0,1,1,0,1,1,0,0 on lv[7:0] MSB first
        for (int i = 8; i >= 0; i--) drive(lv[i]);
        exp_q.push_back(8'hA5);
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL %s_word: got none want %h", tag, e);
            end else begin
                logic [7:0] o;
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++; $display("FAIL %s_word: got %h want %h", tag, o, e);
                end
            end
        end
        n_vec++;
        if (valid_cycles != 1) begin
            n_err++; $display("FAIL %s_valid_cycles: got %0d want 1", tag, valid_cycles);
        end
        n_vec++;
        if (bus.overflow !== 1'b0) begin
            n_err++; $display("FAIL %s_overflow: got %b want 0", tag, bus.overflow);
        end
    endtask

    task automatic test_basic();
        do_reset();
        run_a5("basic");
    endtask

    task automatic test_unstuff();
        logic [9:0] lv;
        do_reset();
        bus.data_ready = 1'b1;
        lv = 10'b0_000000_111;      // ref, six holds, stuff toggle, two holds
        for (int i = 9; i >= 0; i--) drive(lv[i]);
        idle(3);
        n_vec++;
        if (obs_q.size() != 1 || obs_q[0] !== 8'hFF) begin
            n_err++; $display("FAIL unstuff_word: got %0d words first %h want 1 word ff",
                              obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx);
        end
        n_vec++;
        if (stuff_pulses != 0) begin
            n_err++; $display("FAIL unstuff_stuff_err: got %0d pulses want 0", stuff_pulses);
        end
    endtask

    task automatic test_stuff_error();
        do_reset();
        bus.data_ready = 1'b1;
        for (int i = 0; i < 8; i++) drive(1'b0);
        idle(2);
        n_vec++;
        if (stuff_pulses != 1) begin
            n_err++; $display("FAIL stufferr_pulses: got %0d want 1", stuff_pulses);
        end
        n_vec++;
        if (valid_cycles != 0) begin
            n_err++; $display("FAIL stufferr_no_word: got %0d valid cycles want 0", valid_cycles);
        end
        line = 1'b0;
        ones = 0;
        send_word(8'h3C, 1'b1);
        idle(3);
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL stufferr_word: got none want %h", e);
            end else begin
                logic [7:0] o;
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++; $display("FAIL stufferr_word: got %h want %h", o, e);
                end
            end
        end
        n_vec++;
        if (stuff_pulses != 1) begin
            n_err++; $display("FAIL stufferr_pulses_after: got %0d want 1", stuff_pulses);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.data_ready = 1'b0;
        send_ref(1'b0);
        send_word(8'h12, 1'b1);
        send_word(8'h34, 1'b0);
        n_vec++;
        if (bus.data !== 8'h12 || bus.data_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_hold: got %h/%b want 12/1", bus.data, bus.data_valid);
        end
        n_vec++;
        if (bus.overflow !== 1'b1) begin
            n_err++; $display("FAIL bp_overflow: got %b want 1", bus.overflow);
        end
        bus.data_ready = 1'b1;
        idle(1);
        bus.data_ready = 1'b0;
        n_vec++;
        if (bus.data_valid !== 1'b0 || bus.overflow !== 1'b1) begin
            n_err++; $display("FAIL bp_drain: got valid %b ovf %b want 0 1",
                              bus.data_valid, bus.overflow);
        end
        n_vec++;
        if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            n_err++; $display("FAIL bp_word: got %0d words first %h want 1 word 12",
                              obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx);
        end
    endtask

    task automatic test_align();
        do_reset();
        bus.data_ready = 1'b1;
        send_ref(1'b0);
        send_data_bit(1'b1);
        send_data_bit(1'b0);
        send_data_bit(1'b1);
        bus.align   = 1'b1;
        bus.z       = ~line;
        bus.z_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.align   = 1'b0;
        bus.z_valid = 1'b0;
        send_ref(line);
        send_word(8'h5A, 1'b1);
        idle(3);
        n_vec++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            n_err++; $display("FAIL align_word: got %0d words first %h want 1 word 5a",
                              obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx);
        end
        n_vec++;
        if (valid_cycles != 1) begin
            n_err++; $display("FAIL align_valid_cycles: got %0d want 1", valid_cycles);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.data_ready = 1'b0;
        send_ref(1'b0);
        send_word(8'h12, 1'b0);
        send_word(8'h34, 1'b0);
        for (int i = 0; i < 4; i++) send_data_bit(1'b1);
        n_vec++;
        if (bus.data_valid !== 1'b1 || bus.overflow !== 1'b1) begin
            n_err++; $display("FAIL mid_pre: got valid %b ovf %b want 1 1",
                              bus.data_valid, bus.overflow);
        end
        do_reset();
        test_reset();
        run_a5("mid_rerun");
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [6];
        do_reset();
        bus.data_ready = 1'b1;
        words[0] = 8'hFF;
        words[1] = 8'hFF;
        words[2] = 8'h7E;
        words[3] = 8'h80;
        words[4] = 8'($urandom);
        words[5] = 8'($urandom);
        send_ref(1'b1);
        for (int i = 0; i < 6; i++) send_word(words[i], 1'b1);
        idle(3);
        n_vec++;
        if (obs_q.size() != 6) begin
            n_err++; $display("FAIL b2b_count: got %0d words want 6", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e;
            logic [7:0] o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++; $display("FAIL b2b_word: got %h want %h", o, e);
            end
        end
        n_vec++;
        if (stuff_pulses != 0 || bus.overflow !== 1'b0) begin
            n_err++; $display("FAIL b2b_flags: got stuff %0d ovf %b want 0 0",
                              stuff_pulses, bus.overflow);
        end
    endtask

    initial begin
        reset          = 1'b0;
        bus.z          = 1'b0;
        bus.z_valid    = 1'b0;
        bus.align      = 1'b0;
        bus.data_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        do_reset();
        test_reset();
        test_basic();
        test_unstuff();
        test_stuff_error();
        test_backpressure();
        test_align();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
